servo_pulse_decoder: RTL and testbench



---
 rtl/servo_pulse_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pulse_decoder.sv
// Servo/RC pulse decoder: measures the high time of a servo pulse and recovers the 8-bit position code.
// Optional two-sample output averaging is enabled by defining SERVO_DEC_AVG_EN.
module servo_pulse_decoder #(
    parameter int unsigned MIN_COUNT  = 25000,
    parameter int unsigned STEP       = 320,
    parameter int unsigned GLITCH_MIN = 12500,
    parameter int unsigned MAX_WIDTH  = 150000,
    parameter int unsigned TIMEOUT    = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       servo_pulse,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pulse_error,
    output logic       signal_lost
);

    localparam int unsigned CNT_W   = 21;
    localparam int unsigned CODE_W  = 8;
    localparam int unsigned PRESC_W = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [CNT_W-1:0]   MIN_C      = CNT_W'(MIN_COUNT);
    localparam logic [CNT_W-1:0]   GLITCH_C   = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0]   TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP - 1);
    localparam logic [CODE_W-1:0]  CODE_MAX   = '1;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        MEASURE  = 2'd2
    } state_t;

    // Input path: synchronizer and edge detector (free-running, flushed within three cycles)
    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        sync1_q <= servo_pulse;
        sync2_q <= sync1_q;
        level_q <= sync2_q;
        rise_q  <= sync2_q & ~level_q;
        fall_q  <= ~sync2_q & level_q;
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    width_q, width_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   data_q, data_d;
    logic                dv_q, dv_d;
    logic                err_q, err_d;
    logic                lost_q, lost_d;
    logic                decode;
    logic [CODE_W-1:0]   new_code;
`ifdef SERVO_DEC_AVG_EN
    logic [CODE_W-1:0]   prev_code_q, prev_code_d;
    logic                fresh_q, fresh_d;
`endif

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        frame_d  = frame_q;
        presc_d  = presc_q;
        code_d   = code_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        lost_d   = lost_q;
        decode   = 1'b0;
        new_code = code_q;
`ifdef SERVO_DEC_AVG_EN
        prev_code_d = prev_code_q;
        fresh_d     = fresh_q;
`endif

        if (frame_q != TIMEOUT_C) begin
            frame_d = frame_q + CNT_W'(1);
        end

        case (state_q)
            WAIT_LOW: begin
                if (!level_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise_q) begin
                    state_d = MEASURE;
                    width_d = CNT_W'(1);
                    presc_d = '0;
                    code_d  = '0;
                    frame_d = '0;
                end
            end
            MEASURE: begin
                if (level_q) begin
                    if (width_q == MAX_C) begin
                        err_d   = 1'b1;
                        state_d = WAIT_LOW;
                    end else begin
                        width_d = width_q + CNT_W'(1);
                        // code tracks floor((width - MIN_COUNT) / STEP) without a divider
                        if (width_q >= MIN_C) begin
                            if (presc_q == PRESC_LAST) begin
                                presc_d = '0;
                                if (code_q != CODE_MAX) begin
                                    code_d = code_q + CODE_W'(1);
                                end
                            end else begin
                                presc_d = presc_q + PRESC_W'(1);
                            end
                        end
                    end
                end else if (fall_q) begin
                    state_d = ARMED;
                    if (width_q < GLITCH_C) begin
                        err_d = 1'b1;
                    end else begin
                        decode   = 1'b1;
                        new_code = (width_q < MIN_C) ? '0 : code_q;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase

        if ((frame_d == TIMEOUT_C) && (frame_q != TIMEOUT_C)) begin
            lost_d = 1'b1;
        end

        // A decode in the same cycle as a timeout wins
        if (decode) begin
            dv_d   = 1'b1;
            lost_d = 1'b0;
`ifdef SERVO_DEC_AVG_EN
            if (fresh_q || lost_q) begin
                data_d = new_code;
            end else begin
                data_d = CODE_W'(({1'b0, prev_code_q} + {1'b0, new_code}) >> 1);
            end
            prev_code_d = new_code;
            fresh_d     = 1'b0;
`else
            data_d = new_code;
`endif
        end

        if (!enable) begin
            state_d = WAIT_LOW;
            width_d = '0;
            frame_d = '0;
            presc_d = '0;
            code_d  = '0;
            data_d  = data_q;
            dv_d    = 1'b0;
            err_d   = 1'b0;
            lost_d  = lost_q;
`ifdef SERVO_DEC_AVG_EN
            prev_code_d = prev_code_q;
            fresh_d     = 1'b1;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOW;
            width_q <= '0;
            frame_q <= '0;
            presc_q <= '0;
            code_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b1;
`ifdef SERVO_DEC_AVG_EN
            prev_code_q <= '0;
            fresh_q     <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            frame_q <= frame_d;
            presc_q <= presc_d;
            code_q  <= code_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
`ifdef SERVO_DEC_AVG_EN
            prev_code_q <= prev_code_d;
            fresh_q     <= fresh_d;
`endif
        end
    end

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign pulse_error = err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: scaled-down timing, per-cycle model comparison plus literal pins.
module tb_servo_pulse_decoder;

    localparam int MIN  = 100;
    localparam int STEP = 4;
    localparam int GL   = 50;
    localparam int MAXW = 1300;
    localparam int TO   = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       servo_pulse;
    logic [7:0] data;
    logic       data_valid;
    logic       pulse_error;
    logic       signal_lost;

    servo_pulse_decoder #(
        .MIN_COUNT (MIN),
        .STEP      (STEP),
        .GLITCH_MIN(GL),
        .MAX_WIDTH (MAXW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .servo_pulse(servo_pulse),
        .data       (data),
        .data_valid (data_valid),
        .pulse_error(pulse_error),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state
    int exp_data = 0;
    int exp_lost = 1;
    int exp_prev = 0;
    int exp_fresh = 1;
    int frame_ref = 0;
    int ev_kind[int];
    int ev_code[int];
    int ev_ref[int];
    int e_dv;
    int e_err;
    int nc;

    int last_dv_cyc = -1;
    int last_err_cyc = -1;
    int dv_count = 0;
    int err_count = 0;
    int last_rise = 0;
    int last_fall = 0;

    function automatic int code_of(input int w);
        if (w < MIN) return 0;
        if ((w - MIN) / STEP > 255) return 255;
        return (w - MIN) / STEP;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            e_dv  = 0;
            e_err = 0;
            if (data_valid) begin
                last_dv_cyc = cyc;
                dv_count++;
            end
            if (pulse_error) begin
                last_err_cyc = cyc;
                err_count++;
            end
            if (reset) begin
                exp_data  = 0;
                exp_lost  = 1;
                exp_prev  = 0;
                exp_fresh = 1;
                frame_ref = cyc;
                ev_kind.delete();
                ev_code.delete();
                ev_ref.delete();
            end else if (!enable) begin
                exp_fresh = 1;
                frame_ref = cyc;
            end else begin
                if (ev_ref.exists(cyc)) frame_ref = cyc;
                if (ev_kind.exists(cyc)) begin
                    if (ev_kind[cyc] == 1) begin
                        e_dv = 1;
                        nc   = ev_code[cyc];
`ifdef SERVO_DEC_AVG_EN
                        if (exp_fresh != 0 || exp_lost != 0) exp_data = nc;
                        else exp_data = (exp_prev + nc) / 2;
                        exp_prev  = nc;
                        exp_fresh = 0;
`else
                        exp_data = nc;
`endif
                    end else begin
                        e_err = 1;
                    end
                end
                if (cyc == frame_ref + TO) exp_lost = 1;
                if (e_dv != 0) exp_lost = 0;
            end
            chk("data_valid", int'(data_valid), e_dv);
            chk("pulse_error", int'(pulse_error), e_err);
            chk("data", int'(data), exp_data);
            chk("signal_lost", int'(signal_lost), exp_lost);
        end
    end

    // Drive one pulse of w cycles and schedule the expected strobe
    task automatic pulse(input int w, input int gap);
        int c;
        @(negedge clk);
        c = cyc + 1;
        servo_pulse = 1'b1;
        last_rise = c;
        ev_ref[c + 3] = 1;
        if (w > MAXW) begin
            ev_kind[c + MAXW + 3] = 2;
        end else if (w < GL) begin
            ev_kind[c + w + 3] = 2;
        end else begin
            ev_kind[c + w + 3] = 1;
            ev_code[c + w + 3] = code_of(w);
        end
        repeat (w) @(negedge clk);
        servo_pulse = 1'b0;
        last_fall = c + w;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int d0;
        int e0;
        int c;
        reset = 1'b1;
        enable = 1'b1;
        servo_pulse = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_data", int'(data), 0);
        chk("idle_lost", int'(signal_lost), 1);
        chk("idle_no_strobe", dv_count + err_count, 0);

        // Main decode: code 0, 85, 255
        pulse(100, 200);
        chk("latency", last_dv_cyc - last_fall, 3);
        chk("lit_code0", int'(data), 0);
        chk("lit_lost_clear", int'(signal_lost), 0);
        pulse(440, 200);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_code85", int'(data), 42);
`else
        chk("lit_code85", int'(data), 85);
`endif
        pulse(1120, 200);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_code255", int'(data), 170);
`else
        chk("lit_code255", int'(data), 255);
`endif

        // Glitches and boundaries
        e0 = err_count;
        pulse(20, 100);
        chk("glitch_err", err_count - e0, 1);
`ifdef SERVO_DEC_AVG_EN
        chk("glitch_hold", int'(data), 170);
`else
        chk("glitch_hold", int'(data), 255);
`endif
        pulse(49, 100);
        pulse(50, 100);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_glitch_min", int'(data), 127);
`else
        chk("lit_glitch_min", int'(data), 0);
`endif
        pulse(1300, 100);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_max_width", int'(data), 127);
`else
        chk("lit_max_width", int'(data), 255);
`endif
        d0 = dv_count;
        pulse(1301, 100);
        pulse(1400, 100);
        chk("ovl_err_cyc", last_err_cyc - last_rise, 1303);
        chk("ovl_no_dv", dv_count - d0, 0);
        pulse(104, 200);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_code1", int'(data), 128);
`else
        chk("lit_code1", int'(data), 1);
`endif

        // Timeout and recovery
        pulse(500, TO + 200);
        chk("lit_timeout", int'(signal_lost), 1);
        pulse(500, 200);
        chk("lit_code100", int'(data), 100);
        chk("lit_relock", int'(signal_lost), 0);

        // Loopback-style frames at code 128
        repeat (3) pulse(612, 388);
        chk("lit_loop128", int'(data), 128);

        // Input high across reset release: partial pulse ignored
        d0 = dv_count;
        e0 = err_count;
        @(negedge clk);
        reset = 1'b1;
        servo_pulse = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        servo_pulse = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst_high_no_strobe", (dv_count - d0) + (err_count - e0), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_lost", int'(signal_lost), 1);
        pulse(500, 200);
        chk("lit_after_rst", int'(data), 100);
        pulse(904, 200);
`ifdef SERVO_DEC_AVG_EN
        chk("lit_avg", int'(data), 150);
`else
        chk("lit_avg", int'(data), 201);
`endif

        // Enable toggled mid-pulse: that pulse produces no strobe
        d0 = dv_count;
        e0 = err_count;
        @(negedge clk);
        c = cyc + 1;
        servo_pulse = 1'b1;
        ev_ref[c + 3] = 1;
        repeat (200) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (200) @(negedge clk);
        servo_pulse = 1'b0;
        repeat (100) @(negedge clk);
        chk("en_toggle_no_strobe", (dv_count - d0) + (err_count - e0), 0);
        pulse(904, 200);
        chk("lit_raw_after_en", int'(data), 201);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
